vga_write_arbiter: RTL and testbench
====================================

Name: vga_write_arbiter

Overview:
Shares the single write port of the 80x30 VGA text buffer among several game FSMs: player, ghosts, score/HUD. Arbitration is round-robin with a per-request lock. The lock lets a requester write multi-cell sprite updates (erase old cell, draw new cell) atomically. Writes are registered onto vga_addr/vga_we/vga_data, and addresses outside the buffer are rejected.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 12, text-buffer address width
DATA_W, 16, cell word width ({attr[7:0], char[7:0]}, e.g. 16'h0E01)
MAX_ADDR, 2400, number of valid cells (80*30); valid addresses are 0..MAX_ADDR-1
LOCK_MAX, 16, idle cycles a lock owner may hold the port without a transfer

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req  in  N_REQ  per-requester write request; must hold until granted
req_lock  in  N_REQ  hold ownership after this transfer
req_addr  in  N_REQ*ADDR_W  flattened; requester i uses bits [i*ADDR_W +: ADDR_W]
req_data  in  N_REQ*DATA_W  flattened; requester i uses bits [i*DATA_W +: DATA_W]
gnt  out  N_REQ  combinational one-hot grant; transfer = req[i] & gnt[i] at clk edge
vga_addr  out  ADDR_W  registered text-buffer address
vga_we  out  1  registered write enable
vga_data  out  DATA_W  registered cell word
err_oob  out  1  one-cycle pulse: an out-of-range write was dropped
lock_timeout  out  1  one-cycle pulse: a lock was force-released

Behaviour:
- Reset values: vga_we=0, vga_addr=0, vga_data=0, err_oob=0, lock_timeout=0, state=ARB, last_winner=N_REQ-1 (requester 0 has first priority), timeout counter=0.
- gnt is combinational from req and state:
  - at most one bit set;
  - gnt=0 when req=0;
  - a requester advances its addr/data on the edge where req&gnt=1.
- Write latency: 1 cycle. A transfer at edge T produces vga_we=1 with that requester's addr/data during cycle T+1.
- When no transfer occurs, vga_we=0 and vga_addr/vga_data hold their previous values.
- Throughput: one write per cycle, with no bubbles between consecutive transfers.
- State ARB:
  - grant goes to the first requesting index scanning (last_winner+1) mod N_REQ upward with wrap;
  - on transfer, last_winner is updated to the granted index;
  - if req_lock of the winner is 1, go to OWNED(winner) and clear the timeout counter.
- State OWNED(o):
  - only requester o can be granted; all other requests are masked;
  - a transfer with req_lock[o]=1 stays in OWNED and clears the counter;
  - a transfer with req_lock[o]=0 returns to ARB; last_winner=o.
- OWNED cycles with no transfer increment the counter. When the counter reaches LOCK_MAX-1 in a cycle with no transfer:
  - at that edge return to ARB with last_winner=o;
  - lock_timeout=1 for the next cycle;
  - gnt[o] in that cycle is still allowed, and a transfer in that cycle takes precedence over the timeout.
- Out-of-range: if the transfer address is >= MAX_ADDR:
  - the transfer completes (gnt given, lock semantics apply);
  - vga_we stays 0;
  - err_oob=1 for the next cycle;
  - vga_addr/vga_data hold.
- Width rules:
  - the address compare is unsigned, full ADDR_W;
  - the timeout counter is $clog2(LOCK_MAX)+1 bits and saturates;
  - no arithmetic is performed on data.
- Simultaneous events: lock release and new requests in the same cycle behave as follows. The release transfer wins that cycle, and the other requesters are arbitrated from the next cycle.
- Reset mid-operation: rst wins over everything. A transfer in the same cycle as rst produces no write; ownership is dropped and priority returns to requester 0.
- FSM states: ARB, OWNED. The owner index and last_winner are registered separately.

Test Plan:
- req=0001, addr0=810, data0=16'h0E01 -> gnt=0001 same cycle; next cycle vga_we=1, vga_addr=810, vga_data=16'h0E01; then vga_we=0.
- req=1111 held, each requester holds req until granted and then re-requests -> gnt sequence 0,1,2,3,0,1; vga_we=1 every cycle; each vga_data matches the granted requester.
- req1 with lock=1 writes addr 811 data 0x0E02, then lock=0 writes addr 810 data 0x0E00, while req2 is held -> gnt 0010,0010,0100; req2 is never granted in between.
- req1 lock=1 transfer, then req1 deasserted and req2 held, LOCK_MAX=16 -> gnt2=0 for 16 cycles; lock_timeout pulses once; req2 is granted the following cycle.
- addr=2400 -> gnt asserted, vga_we stays 0, err_oob=1 for one cycle; addr=2399 -> normal write.
- rst=1 in the transfer cycle of req3 while in OWNED(3) -> no vga_we, all outputs 0; with req=1001 after reset, requester 0 is granted first.

Source files
------------

// File: rtl/vga_write_arbiter.sv
// rtl/vga_write_arbiter.sv - round-robin arbiter with per-requester lock for the VGA text-buffer write port
module vga_write_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int MAX_ADDR = 2400,
  parameter int LOCK_MAX = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_lock,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  output logic [ADDR_W-1:0]         vga_addr,
  output logic                      vga_we,
  output logic [DATA_W-1:0]         vga_data,
  output logic                      err_oob,
  output logic                      lock_timeout
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(LOCK_MAX) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOCK_MAX - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT  = '1;
  localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(MAX_ADDR);

  typedef enum logic {ARB, OWNED} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   vga_addr_q, vga_addr_d;
  logic [DATA_W-1:0]   vga_data_q, vga_data_d;
  logic                vga_we_q, vga_we_d;
  logic                err_oob_q, err_oob_d;
  logic                lock_timeout_q, lock_timeout_d;

  logic                found;
  logic [IDX_W-1:0]    win;
  logic [IDX_W-1:0]    cand;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic                in_range;

  // Owner masks everyone else; otherwise scan upward from the slot after the last winner.
  always_comb begin
    found = 1'b0;
    win   = owner_q;
    cand  = '0;
    if (state_q == OWNED) begin
      found = req[owner_q];
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        cand = IDX_W'((int'(last_q) + k) % N_REQ);
        if (!found && req[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (found) gnt[win] = 1'b1;
    win_addr = req_addr[int'(win)*ADDR_W +: ADDR_W];
    win_data = req_data[int'(win)*DATA_W +: DATA_W];
    in_range = {1'b0, win_addr} < ADDR_LIM;
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    vga_addr_d     = vga_addr_q;
    vga_data_d     = vga_data_q;
    vga_we_d       = 1'b0;
    err_oob_d      = 1'b0;
    lock_timeout_d = 1'b0;

    if (found) begin
      if (in_range) begin
        vga_we_d   = 1'b1;
        vga_addr_d = win_addr;
        vga_data_d = win_data;
      end else begin
        err_oob_d = 1'b1;
      end
    end

    case (state_q)
      ARB: begin
        if (found) begin
          last_d = win;
          if (req_lock[win]) begin
            state_d = OWNED;
            owner_d = win;
            cnt_d   = '0;
          end
        end
      end
      OWNED: begin
        if (found) begin
          if (req_lock[owner_q]) begin
            cnt_d = '0;
          end else begin
            state_d = ARB;
            last_d  = owner_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d        = ARB;
          last_d         = owner_q;
          lock_timeout_d = 1'b1;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ARB;
      owner_q        <= '0;
      last_q         <= IDX_W'(N_REQ - 1);
      cnt_q          <= '0;
      vga_addr_q     <= '0;
      vga_data_q     <= '0;
      vga_we_q       <= 1'b0;
      err_oob_q      <= 1'b0;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_q         <= last_d;
      cnt_q          <= cnt_d;
      vga_addr_q     <= vga_addr_d;
      vga_data_q     <= vga_data_d;
      vga_we_q       <= vga_we_d;
      err_oob_q      <= err_oob_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  assign vga_addr     = vga_addr_q;
  assign vga_data     = vga_data_q;
  assign vga_we       = vga_we_q;
  assign err_oob      = err_oob_q;
  assign lock_timeout = lock_timeout_q;
endmodule

// File: tb/tb_vga_write_arbiter.sv
// tb/tb_vga_write_arbiter.sv - directed and randomized checks of vga_write_arbiter against a cycle-level model
module tb_vga_write_arbiter;
  localparam int N    = 4;
  localparam int AW   = 12;
  localparam int DW   = 16;
  localparam int MAXA = 2400;
  localparam int LMAX = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_lock, gnt;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [AW-1:0]   vga_addr;
  logic            vga_we;
  logic [DW-1:0]   vga_data;
  logic            err_oob, lock_timeout;

  vga_write_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_ADDR(MAXA), .LOCK_MAX(LMAX)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data), .gnt(gnt),
    .vga_addr(vga_addr), .vga_we(vga_we), .vga_data(vga_data),
    .err_oob(err_oob), .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: ownership flag, owner, last winner and a count of idle owned cycles.
  bit            m_owned = 1'b0;
  int            m_owner = 0;
  int            m_last  = N - 1;
  int            m_idle  = 0;
  logic          e_we, e_oob, e_to;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  int            last_w = -1;
  logic [N-1:0]  g_obs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick();
    if (m_owned) return req[m_owner] ? m_owner : -1;
    for (int k = 1; k <= N; k++) begin
      int i = (m_last + k) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic step();
    int w;
    logic [AW-1:0] a;
    #1;
    w = pick();
    g_obs = gnt;
    check("gnt", 32'(gnt), (w >= 0) ? (32'd1 << w) : 32'd0);
    @(posedge clk);
    e_we = 1'b0; e_oob = 1'b0; e_to = 1'b0;
    if (rst) begin
      m_owned = 1'b0; m_last = N - 1; m_idle = 0;
      e_addr = '0; e_data = '0; w = -1;
    end else if (w >= 0) begin
      a = req_addr[w*AW +: AW];
      if (a < MAXA) begin
        e_we = 1'b1; e_addr = a; e_data = req_data[w*DW +: DW];
      end else begin
        e_oob = 1'b1;
      end
      m_last = w;
      if (req_lock[w]) begin
        m_owned = 1'b1; m_owner = w; m_idle = 0;
      end else begin
        m_owned = 1'b0;
      end
    end else if (m_owned) begin
      m_idle++;
      if (m_idle == LMAX) begin
        m_owned = 1'b0; m_last = m_owner; e_to = 1'b1;
      end
    end
    last_w = w;
    #1;
    check("vga_we", 32'(vga_we), 32'(e_we));
    check("vga_addr", 32'(vga_addr), 32'(e_addr));
    check("vga_data", 32'(vga_data), 32'(e_data));
    check("err_oob", 32'(err_oob), 32'(e_oob));
    check("lock_timeout", 32'(lock_timeout), 32'(e_to));
  endtask

  task automatic set_req(input int i, input bit r, input bit lk, input int a, input int d);
    req[i] = r;
    req_lock[i] = lk;
    req_addr[i*AW +: AW] = AW'(a);
    req_data[i*DW +: DW] = DW'(d);
  endtask

  task automatic do_reset();
    req = '0; req_lock = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic new_req(input int i);
    int sel, a;
    sel = $urandom_range(0, 9);
    a = (sel == 0) ? 2400 : (sel == 1) ? 2399 : (sel == 2) ? 4095 : $urandom_range(0, 2399);
    set_req(i, 1'b1, ($urandom_range(0, 2) == 0), a, $urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int zeros, pulses;
    req = '0; req_lock = '0; req_addr = '0; req_data = '0;
    rst = 1'b1;
    step();
    do_reset();
    check("rst_we", 32'(vga_we), 32'd0);
    check("rst_addr", 32'(vga_addr), 32'd0);
    check("rst_data", 32'(vga_data), 32'd0);
    check("rst_oob", 32'(err_oob), 32'd0);
    check("rst_to", 32'(lock_timeout), 32'd0);

    // Single write with one-cycle latency.
    set_req(0, 1'b1, 1'b0, 810, 'h0E01);
    step();
    check("t1_gnt", 32'(g_obs), 32'b0001);
    check("t1_we", 32'(vga_we), 32'd1);
    check("t1_addr", 32'(vga_addr), 32'd810);
    check("t1_data", 32'(vga_data), 32'h0E01);
    req[0] = 1'b0;
    step();
    check("t1_we_off", 32'(vga_we), 32'd0);
    check("t1_addr_hold", 32'(vga_addr), 32'd810);

    // Round-robin under full load.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 100 + i, 'h0100 + i);
    for (int k = 0; k < 6; k++) begin
      step();
      check("t2_gnt", 32'(g_obs), 32'd1 << (k % N));
      check("t2_we", 32'(vga_we), 32'd1);
      check("t2_data", 32'(vga_data), 32'h0100 + 32'(k % N));
    end

    // Locked two-cell update keeps requester 2 out.
    do_reset();
    set_req(1, 1'b1, 1'b1, 811, 'h0E02);
    set_req(2, 1'b1, 1'b0, 5, 'h0E05);
    step();
    check("t3_gnt_a", 32'(g_obs), 32'b0010);
    set_req(1, 1'b1, 1'b0, 810, 'h0E00);
    step();
    check("t3_gnt_b", 32'(g_obs), 32'b0010);
    check("t3_data_b", 32'(vga_data), 32'h0E00);
    req[1] = 1'b0;
    step();
    check("t3_gnt_c", 32'(g_obs), 32'b0100);

    // Lock timeout.
    do_reset();
    set_req(1, 1'b1, 1'b1, 20, 'h0E07);
    set_req(2, 1'b1, 1'b0, 21, 'h0E08);
    step();
    check("t4_gnt_lock", 32'(g_obs), 32'b0010);
    req[1] = 1'b0;
    zeros = 0; pulses = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      pulses += int'(lock_timeout);
      if (g_obs[2]) break;
      zeros++;
    end
    check("t4_blocked_cycles", 32'(zeros), 32'd16);
    check("t4_timeout_pulses", 32'(pulses), 32'd1);
    req[2] = 1'b0;

    // Out-of-range boundary.
    do_reset();
    set_req(0, 1'b1, 1'b0, 2400, 'h0E09);
    step();
    check("t5_gnt", 32'(g_obs), 32'b0001);
    check("t5_we", 32'(vga_we), 32'd0);
    check("t5_oob", 32'(err_oob), 32'd1);
    set_req(0, 1'b1, 1'b0, 2399, 'h1234);
    step();
    check("t5_we_ok", 32'(vga_we), 32'd1);
    check("t5_addr_ok", 32'(vga_addr), 32'd2399);
    check("t5_oob_off", 32'(err_oob), 32'd0);

    // Reset during an owned transfer.
    do_reset();
    set_req(3, 1'b1, 1'b1, 7, 'h0E0A);
    step();
    set_req(3, 1'b1, 1'b1, 8, 'h0E0B);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_we", 32'(vga_we), 32'd0);
    check("t6_addr", 32'(vga_addr), 32'd0);
    check("t6_data", 32'(vga_data), 32'd0);
    set_req(0, 1'b1, 1'b0, 9, 'h0E0C);
    step();
    check("t6_gnt", 32'(g_obs), 32'b0001);

    // Randomized traffic with bursts, idle periods, locks and occasional reset.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int p;
      p = ((c / 300) % 2 == 1) ? 60 : 8;
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < N; i++) begin
        if (req[i] && i == last_w) begin
          if ($urandom_range(0, 99) < p) new_req(i);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 99) < p) begin
          new_req(i);
        end
      end
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
